pacman_mover: RTL and testbench
===============================

// Module: pacman_mover
// PURPOSE
//   Player-side position generator: produces the p_x/p_y pair consumed by each monster
//   chaser. Turns button requests into a buffered turn, moves one pixel per move_tick,
//   obeys direction_flag wall flags, wraps through the horizontal tunnel.
//   Sits between button debouncer / direction_flag and the monsters + VGA renderer.
// PARAMETERS
//   START_X   160  reset x position (pixels)
//   START_Y   232  reset y position (pixels)
//   MAP_W     320  map width; x wraps over [0, MAP_W-1]
//   VELOCITY  1    pixels moved per accepted step
// PORTS
//   clk_50mhz  in   1  system clock; all logic on posedge
//   rst_n      in   1  synchronous, active-low reset
//   move_tick  in   1  one-cycle step strobe (movement rate)
//   freeze     in   1  1 = hold position/direction (death, pause)
//   btn_req    in   4  {L,U,R,D} raw request, level, may be multi-hot
//   flag_L     in   3  direction_flag output for p_x/p_y; nonzero = left free
//   flag_U     in   3  up free when nonzero
//   flag_R     in   3  right free when nonzero
//   flag_D     in   3  down free when nonzero
//   p_x        out  9  player x
//   p_y        out  9  player y
//   cur_dir    out  4  one-hot current heading {L,U,R,D}
//   moving     out  1  1 = last tick produced a step
//   anim_phase out  2  mouth frame, +1 per actual step
// BEHAVIOUR
//   Reset (rst_n=0 at edge): p_x=START_X, p_y=START_Y, cur_dir=L(4'b1000), moving=0,
//     anim_phase=0, pend_valid=0, pend_dir=0, state=STOP. move_tick ignored during reset.
//   Request capture (every cycle, freeze=0): btn_req!=0 -> pend_dir <= priority-encoded
//     one-hot (L>U>R>D), pend_valid<=1; newer request overwrites. btn_req=0 keeps pending.
//   States: STOP (blocked), MOVE (stepping). Evaluated only on move_tick=1 & freeze=0:
//     1. pend_valid & flag[pend_dir]!=0 -> cur_dir<=pend_dir, pend_valid<=0, step pend_dir, MOVE.
//     2. else flag[cur_dir]!=0 -> step cur_dir, MOVE (pending kept for later corner).
//     3. else no step, moving<=0, STOP; cur_dir unchanged; pending kept.
//   Step: L x-=V, R x+=V, U y-=V, D y+=V; moving<=1, anim_phase+=1 (mod 4).
//   Wrap: stepping L with p_x<V -> p_x<=MAP_W-V+p_x; stepping R with p_x+V>MAP_W-1 ->
//     p_x<=p_x+V-MAP_W. y never wraps; relies on flags (no y bounds check).
//   Latency: position/cur_dir update on the edge where move_tick=1; flags used are those
//     present at that edge (direction_flag's one-cycle lag is absorbed: ticks >=2 cycles apart).
//   Simultaneous btn_req and move_tick same edge: tick uses pend_dir registered before the
//     edge; the new request is captured and applies from next tick.
//   Reversal: same rules (no special-case); opposite side is normally free so it is immediate.
//   freeze=1: no capture, no step, moving<=0, pend_valid<=0; outputs otherwise hold.
//   Reset mid-operation: full reset values on the next edge, pending discarded.
//   Multi-hot cur_dir never occurs; flags all zero in STOP -> stays STOP indefinitely.
// STRUCTURE
//   Shared include pacman_defs.vh: DIR_L/U/R/D one-hot constants, MAP_W, start positions,
//     9-bit coordinate width; reused by monster logic and renderer.
//   Sub-module dir_priority_enc: 4-bit multi-hot -> one-hot (L>U>R>D), combinational.
//   Main body: request register, STOP/MOVE FSM, position/wrap datapath, anim counter.
// TESTING
//   1 Reset, flag_L=1, 3 ticks -> p_x=157, p_y=232, cur_dir=L, moving=1, anim_phase=3.
//   2 Moving L, btn_req=U pulsed once with flag_U=0 for 2 ticks then flag_U=1 -> keeps L
//     2 steps, then turns U on 3rd tick: p_y=231, pend_valid=0.
//   3 Heading R, flag_R=0 -> no change to p_x, moving=0, STOP; then btn_req=L, flag_L=1,
//     tick -> p_x-1, cur_dir=L.
//   4 p_x=0 heading L, flag_L=1, tick -> p_x=319; p_x=319 heading R, tick -> p_x=0.
//   5 btn_req=4'b1111 -> pend_dir=L; btn_req=R and move_tick on same edge -> tick uses
//     old pending L, next tick uses R.
//   6 freeze=1 for 5 ticks -> outputs constant, moving=0; rst_n=0 mid-MOVE -> (160,232), L.

Source files
------------

// File: rtl/pacman_mover_pkg.sv
`default_nettype none
// ============================================================================
// Module : pacman_mover_pkg
// Brief  : Shared direction encodings, map geometry and coordinate width
//          for the player mover, monster chasers and renderer.
// Rev    : 1.0  initial release
// ============================================================================
package pacman_mover_pkg;

   localparam int COORD_W   = 9;
   localparam int MAP_W_DEF = 320;
   localparam int START_X_DEF = 160;
   localparam int START_Y_DEF = 232;
   localparam int VELOCITY_DEF = 1;

   localparam logic [3:0] DIR_L = 4'b1000;
   localparam logic [3:0] DIR_U = 4'b0100;
   localparam logic [3:0] DIR_R = 4'b0010;
   localparam logic [3:0] DIR_D = 4'b0001;

   typedef enum logic [0:0] {
      ST_STOP = 1'b0,
      ST_MOVE = 1'b1
   } mover_state_t;

   // A direction is open when the wall flag for that side is nonzero.
   function automatic logic dir_free(input logic [3:0] dir,
                                     input logic [2:0] fl,
                                     input logic [2:0] fu,
                                     input logic [2:0] fr,
                                     input logic [2:0] fd);
      logic r;
      r = 1'b0;
      if (dir[3])      r = |fl;
      else if (dir[2]) r = |fu;
      else if (dir[1]) r = |fr;
      else if (dir[0]) r = |fd;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pacman_mover_dir_priority_enc.sv
`default_nettype none
// ============================================================================
// Module : pacman_mover_dir_priority_enc
// Brief  : Multi-hot button request to one-hot heading, priority L>U>R>D.
// Rev    : 1.0  initial release
// ============================================================================
module pacman_mover_dir_priority_enc
   import pacman_mover_pkg::*;
(
   input  logic [3:0] i_req,
   output logic [3:0] o_onehot
);

   always_comb begin
      o_onehot = 4'b0000;
      if (i_req[3])      o_onehot = DIR_L;
      else if (i_req[2]) o_onehot = DIR_U;
      else if (i_req[1]) o_onehot = DIR_R;
      else if (i_req[0]) o_onehot = DIR_D;
   end

endmodule
`default_nettype wire

// File: rtl/pacman_mover.sv
`default_nettype none
// ============================================================================
// Module : pacman_mover
// Brief  : Player position generator: buffered turns, one step per move_tick,
//          wall flags, horizontal tunnel wrap.
// Rev    : 1.0  initial release
// ============================================================================
module pacman_mover
   import pacman_mover_pkg::*;
#(
   parameter int START_X  = START_X_DEF,
   parameter int START_Y  = START_Y_DEF,
   parameter int MAP_W    = MAP_W_DEF,
   parameter int VELOCITY = VELOCITY_DEF
) (
   input  logic               clk_50mhz,
   input  logic               rst_n,
   input  logic               move_tick,
   input  logic               freeze,
   input  logic [3:0]         btn_req,
   input  logic [2:0]         flag_L,
   input  logic [2:0]         flag_U,
   input  logic [2:0]         flag_R,
   input  logic [2:0]         flag_D,
   output logic [COORD_W-1:0] p_x,
   output logic [COORD_W-1:0] p_y,
   output logic [3:0]         cur_dir,
   output logic               moving,
   output logic [1:0]         anim_phase
);

   localparam logic [COORD_W-1:0] c_vel      = COORD_W'(VELOCITY);
   localparam logic [COORD_W-1:0] c_wrap_gap = COORD_W'(MAP_W - VELOCITY);

   mover_state_t       r_state;
   logic [3:0]         r_pend_dir;
   logic               r_pend_valid;
   logic [3:0]         w_req_onehot;
   logic               w_pend_free;
   logic               w_cur_free;
   logic               w_can_step;
   logic [3:0]         w_step_dir;
   logic [COORD_W-1:0] w_next_x;
   logic [COORD_W-1:0] w_next_y;

   pacman_mover_dir_priority_enc u_enc (
      .i_req    (btn_req),
      .o_onehot (w_req_onehot)
   );

   assign w_pend_free = r_pend_valid & dir_free(r_pend_dir, flag_L, flag_U, flag_R, flag_D);
   assign w_cur_free  = dir_free(cur_dir, flag_L, flag_U, flag_R, flag_D);
   assign w_can_step  = w_pend_free | w_cur_free;
   assign w_step_dir  = w_pend_free ? r_pend_dir : cur_dir;
   assign moving      = (r_state == ST_MOVE);

   // Tunnel wrap on x only; y relies on the wall flags to stay in range.
   always_comb begin
      w_next_x = p_x;
      w_next_y = p_y;
      if (w_step_dir == DIR_L)
         w_next_x = (p_x < c_vel) ? p_x + c_wrap_gap : p_x - c_vel;
      else if (w_step_dir == DIR_R)
         w_next_x = (p_x >= c_wrap_gap) ? p_x - c_wrap_gap : p_x + c_vel;
      else if (w_step_dir == DIR_U)
         w_next_y = p_y - c_vel;
      else if (w_step_dir == DIR_D)
         w_next_y = p_y + c_vel;
   end

   always_ff @(posedge clk_50mhz) begin
      if (!rst_n) begin
         p_x          <= COORD_W'(START_X);
         p_y          <= COORD_W'(START_Y);
         cur_dir      <= DIR_L;
         anim_phase   <= 2'd0;
         r_pend_dir   <= 4'b0000;
         r_pend_valid <= 1'b0;
         r_state      <= ST_STOP;
      end else if (freeze) begin
         r_pend_valid <= 1'b0;
         r_state      <= ST_STOP;
      end else begin
         if (move_tick) begin
            if (w_pend_free) begin
               cur_dir      <= r_pend_dir;
               r_pend_valid <= 1'b0;
            end
            if (w_can_step) begin
               p_x        <= w_next_x;
               p_y        <= w_next_y;
               anim_phase <= anim_phase + 2'd1;
               r_state    <= ST_MOVE;
            end else begin
               r_state    <= ST_STOP;
            end
         end
         // A request on the tick edge is captured after the tick used the old one.
         if (btn_req != 4'b0000) begin
            r_pend_dir   <= w_req_onehot;
            r_pend_valid <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pacman_mover.sv
`default_nettype none
// ============================================================================
// Module : tb_pacman_mover
// Brief  : Scoreboard bench for pacman_mover walking the player through turns,
//          blocking, tunnel wrap, same-edge requests, freeze and reset.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pacman_mover;

   typedef struct packed {
      logic [8:0] x;
      logic [8:0] y;
      logic [3:0] dir;
      logic       mv;
      logic [1:0] ph;
   } exp_t;

   localparam logic [3:0] c_l = 4'b1000;
   localparam logic [3:0] c_u = 4'b0100;
   localparam logic [3:0] c_r = 4'b0010;

   logic       clk_50mhz = 1'b0;
   logic       rst_n     = 1'b0;
   logic       move_tick = 1'b0;
   logic       freeze    = 1'b0;
   logic [3:0] btn_req   = 4'b0000;
   logic [2:0] flag_L    = 3'd0;
   logic [2:0] flag_U    = 3'd0;
   logic [2:0] flag_R    = 3'd0;
   logic [2:0] flag_D    = 3'd0;
   logic [8:0] p_x;
   logic [8:0] p_y;
   logic [3:0] cur_dir;
   logic       moving;
   logic [1:0] anim_phase;

   exp_t sb[$];
   exp_t obs;
   exp_t exp_v;
   int   errors = 0;
   int   checks = 0;

   always #10 clk_50mhz = ~clk_50mhz;

   pacman_mover dut (
      .clk_50mhz  (clk_50mhz),
      .rst_n      (rst_n),
      .move_tick  (move_tick),
      .freeze     (freeze),
      .btn_req    (btn_req),
      .flag_L     (flag_L),
      .flag_U     (flag_U),
      .flag_R     (flag_R),
      .flag_D     (flag_D),
      .p_x        (p_x),
      .p_y        (p_y),
      .cur_dir    (cur_dir),
      .moving     (moving),
      .anim_phase (anim_phase)
   );

   function automatic exp_t mk(input int x, input int y, input logic [3:0] d,
                               input logic mv, input int ph);
      exp_t e;
      e.x = 9'(x); e.y = 9'(y); e.dir = d; e.mv = mv; e.ph = 2'(ph);
      return e;
   endfunction

   task automatic set_flags(input logic l, input logic u, input logic r, input logic d);
      flag_L = {2'b00, l}; flag_U = {2'b00, u}; flag_R = {2'b00, r}; flag_D = {2'b00, d};
   endtask

   // One-cycle tick; returns on the falling edge after the tick edge.
   task automatic pulse_tick();
      @(negedge clk_50mhz); move_tick = 1'b1;
      @(negedge clk_50mhz); move_tick = 1'b0;
   endtask

   task automatic pulse_btn(input logic [3:0] b);
      @(negedge clk_50mhz); btn_req = b;
      @(negedge clk_50mhz); btn_req = 4'b0000;
   endtask

   task automatic test_reset();
      @(negedge clk_50mhz); rst_n = 1'b0; move_tick = 1'b1; set_flags(1, 1, 1, 1);
      sb.push_back(mk(160, 232, c_l, 1'b0, 0));
      @(negedge clk_50mhz);
      @(negedge clk_50mhz);
      obs = {p_x, p_y, cur_dir, moving, anim_phase};
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset: got %h need %h", obs, exp_v);
      end
      rst_n = 1'b1; move_tick = 1'b0; set_flags(0, 0, 0, 0);
   endtask

   task automatic test_straight();
      set_flags(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         sb.push_back(mk(159 - i, 232, c_l, 1'b1, i + 1));
         pulse_tick();
         obs = {p_x, p_y, cur_dir, moving, anim_phase};
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL straight[%0d]: got %h need %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_buffered_turn();
      pulse_btn(c_u);
      sb.push_back(mk(156, 232, c_l, 1'b1, 0));
      sb.push_back(mk(155, 232, c_l, 1'b1, 1));
      sb.push_back(mk(155, 231, c_u, 1'b1, 2));
      for (int i = 0; i < 3; i++) begin
         if (i == 2) set_flags(1, 1, 0, 0);
         pulse_tick();
         obs = {p_x, p_y, cur_dir, moving, anim_phase};
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL buffered_turn[%0d]: got %h need %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_blocked();
      set_flags(0, 1, 1, 0);
      pulse_btn(c_r);
      sb.push_back(mk(156, 231, c_r, 1'b1, 3));
      sb.push_back(mk(156, 231, c_r, 1'b0, 3));
      sb.push_back(mk(155, 231, c_l, 1'b1, 0));
      for (int i = 0; i < 3; i++) begin
         if (i == 1) set_flags(0, 0, 0, 0);
         if (i == 2) begin
            pulse_btn(c_r | c_l);
            set_flags(1, 0, 0, 0);
         end
         pulse_tick();
         obs = {p_x, p_y, cur_dir, moving, anim_phase};
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL blocked[%0d]: got %h need %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_wrap();
      set_flags(1, 0, 0, 0);
      for (int i = 0; i < 156; i++) begin
         sb.push_back(mk((i == 155) ? 319 : 154 - i, 231, c_l, 1'b1, (i + 1) % 4));
         pulse_tick();
         obs = {p_x, p_y, cur_dir, moving, anim_phase};
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL wrap_left[%0d]: got %h need %h", i, obs, exp_v);
         end
      end
      set_flags(1, 0, 1, 0);
      pulse_btn(c_r);
      sb.push_back(mk(0, 231, c_r, 1'b1, 1));
      sb.push_back(mk(1, 231, c_r, 1'b1, 2));
      for (int i = 0; i < 2; i++) begin
         pulse_tick();
         obs = {p_x, p_y, cur_dir, moving, anim_phase};
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL wrap_right[%0d]: got %h need %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      set_flags(1, 0, 1, 0);
      pulse_btn(4'b1111);
      sb.push_back(mk(0, 231, c_l, 1'b1, 3));
      sb.push_back(mk(1, 231, c_r, 1'b1, 0));
      @(negedge clk_50mhz); btn_req = c_r; move_tick = 1'b1;
      @(negedge clk_50mhz); btn_req = 4'b0000; move_tick = 1'b0;
      obs = {p_x, p_y, cur_dir, moving, anim_phase};
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL same_edge_old: got %h need %h", obs, exp_v);
      end
      pulse_tick();
      obs = {p_x, p_y, cur_dir, moving, anim_phase};
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL same_edge_new: got %h need %h", obs, exp_v);
      end
   endtask

   task automatic test_freeze_reset();
      set_flags(1, 0, 1, 0);
      pulse_btn(c_u);
      @(negedge clk_50mhz); freeze = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sb.push_back(mk(1, 231, c_r, 1'b0, 0));
         if (i == 2) pulse_btn(c_l);
         pulse_tick();
         obs = {p_x, p_y, cur_dir, moving, anim_phase};
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL freeze[%0d]: got %h need %h", i, obs, exp_v);
         end
      end
      @(negedge clk_50mhz); freeze = 1'b0; set_flags(1, 1, 1, 0);
      sb.push_back(mk(2, 231, c_r, 1'b1, 1));
      pulse_tick();
      obs = {p_x, p_y, cur_dir, moving, anim_phase};
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL unfreeze: got %h need %h", obs, exp_v);
      end
      set_flags(1, 0, 1, 0);
      pulse_btn(c_u);
      @(negedge clk_50mhz); rst_n = 1'b0;
      sb.push_back(mk(160, 232, c_l, 1'b0, 0));
      @(negedge clk_50mhz); rst_n = 1'b1;
      obs = {p_x, p_y, cur_dir, moving, anim_phase};
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL mid_reset: got %h need %h", obs, exp_v);
      end
      set_flags(1, 1, 0, 0);
      sb.push_back(mk(159, 232, c_l, 1'b1, 1));
      pulse_tick();
      obs = {p_x, p_y, cur_dir, moving, anim_phase};
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_drops_pending: got %h need %h", obs, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_straight();
      test_buffered_turn();
      test_blocked();
      test_wrap();
      test_back_to_back();
      test_freeze_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
